// File: rtl/nios_dmem_width_bridge_pkg.sv
// Shared types and helpers for the Nios II 32-bit to 128-bit on-chip RAM bridge.
package nios_dmem_pkg;

  localparam int unsigned LANES    = 4;
  localparam int unsigned LANE_LSB = 2;
  localparam int unsigned LINE_LSB = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RD_RESP  = 3'd4
  } state_t;

  function automatic logic [15:0] lane_be(input logic [3:0] be4, input logic [1:0] lane);
    return {12'd0, be4} << {lane, 2'b00};
  endfunction

  function automatic logic [31:0] lane_sel(input logic [127:0] line128, input logic [1:0] lane);
    return line128[{lane, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/nios_dmem_width_bridge_if.sv
// CPU-side 32-bit Avalon-MM bus and RAM-side 128-bit s1 bus of the width bridge.
interface nios_dmem_width_bridge_if #(
  parameter int unsigned LINE_AW = 15
);
  logic [LINE_AW+3:0] s_address;
  logic               s_read;
  logic               s_write;
  logic [3:0]         s_byteenable;
  logic [31:0]        s_writedata;
  logic               s_waitrequest;
  logic [31:0]        s_readdata;
  logic               s_readdatavalid;

  modport master (
    output s_address, s_read, s_write, s_byteenable, s_writedata,
    input  s_waitrequest, s_readdata, s_readdatavalid
  );
  modport slave (
    input  s_address, s_read, s_write, s_byteenable, s_writedata,
    output s_waitrequest, s_readdata, s_readdatavalid
  );
endinterface

interface nios_dmem_ram_if #(
  parameter int unsigned LINE_AW = 15
);
  logic [LINE_AW-1:0] m_address;
  logic [15:0]        m_byteenable;
  logic               m_chipselect;
  logic               m_write;
  logic [127:0]       m_writedata;
  logic               m_clken;
  logic [127:0]       m_readdata;

  modport master (
    output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
    input  m_readdata
  );
  modport slave (
    input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
    output m_readdata
  );
endinterface

// File: rtl/nios_dmem_line_buf.sv
// One-line read buffer: 128-bit data with tag/valid, byte-merge on write, lane read mux.
module nios_dmem_line_buf
  import nios_dmem_pkg::*;
#(
  parameter int unsigned LINE_AW = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [LINE_AW-1:0] lookup_tag,
  output logic               hit,
  input  logic               merge_en,
  input  logic [1:0]         merge_lane,
  input  logic [3:0]         merge_be,
  input  logic [31:0]        merge_data,
  input  logic               fill_en,
  input  logic [LINE_AW-1:0] fill_tag,
  input  logic [127:0]       fill_data,
  input  logic [1:0]         rd_lane,
  output logic [31:0]        rd_data
);

  logic [127:0]       data;
  logic [LINE_AW-1:0] tag;
  logic               valid;
  logic [15:0]        be16;
  logic [127:0]       wd128;

  assign be16    = lane_be(merge_be, merge_lane);
  assign wd128   = {4{merge_data}};
  assign hit     = valid && (tag == lookup_tag);
  assign rd_data = lane_sel(data, rd_lane);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data  <= '0;
      tag   <= '0;
      valid <= 1'b0;
    end else if (fill_en) begin
      data  <= fill_data;
      tag   <= fill_tag;
      valid <= 1'b1;
    end else if (merge_en) begin
      for (int unsigned b = 0; b < 16; b++) begin
        if (be16[b]) data[8*b +: 8] <= wd128[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/nios_dmem_width_bridge.sv
// Nios II 32-bit data master to 128-bit single-port RAM bridge with a one-line read buffer.
module nios_dmem_width_bridge
  import nios_dmem_pkg::*;
#(
  parameter int unsigned LINE_AW = 15,
  parameter int unsigned DEPTH   = 25000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  nios_dmem_width_bridge_if.slave s,
  nios_dmem_ram_if.master         m
);

  localparam logic [LINE_AW:0] DEPTH_W = (LINE_AW+1)'(DEPTH);

  state_t             state;
  logic [LINE_AW-1:0] req_line;
  logic [LINE_AW-1:0] line_q;
  logic [1:0]         req_lane;
  logic [1:0]         lane_q;
  logic               req_oor;
  logic               oor_q;
  logic               buf_hit;
  logic               accept_wr;
  logic               accept_rd;
  logic               merge_en;
  logic               fill_en;
  logic [31:0]        buf_word;
  logic               unused_addr_lsb;

  assign req_line        = s.s_address[LINE_LSB +: LINE_AW];
  assign req_lane        = s.s_address[LANE_LSB +: 2];
  assign unused_addr_lsb = ^s.s_address[1:0];
  assign req_oor         = {1'b0, req_line} >= DEPTH_W;

  // Write has priority; a read presented together with a write is dropped.
  assign accept_wr = (state == IDLE) && s.s_write;
  assign accept_rd = (state == IDLE) && s.s_read && !s.s_write;
  assign merge_en  = accept_wr && !req_oor && buf_hit;
  assign fill_en   = (state == RD_WAIT);

  nios_dmem_line_buf #(
    .LINE_AW (LINE_AW)
  ) u_line_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .lookup_tag (req_line),
    .hit        (buf_hit),
    .merge_en   (merge_en),
    .merge_lane (req_lane),
    .merge_be   (s.s_byteenable),
    .merge_data (s.s_writedata),
    .fill_en    (fill_en),
    .fill_tag   (line_q),
    .fill_data  (m.m_readdata),
    .rd_lane    (lane_q),
    .rd_data    (buf_word)
  );

  assign s.s_waitrequest   = (state != IDLE);
  assign s.s_readdatavalid = (state == RD_RESP);
  assign s.s_readdata      = (state == RD_RESP && !oor_q) ? buf_word : '0;
  assign m.m_clken         = 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      line_q         <= '0;
      lane_q         <= '0;
      oor_q          <= 1'b0;
      m.m_address    <= '0;
      m.m_byteenable <= '0;
      m.m_chipselect <= 1'b0;
      m.m_write      <= 1'b0;
      m.m_writedata  <= '0;
    end else begin
      m.m_chipselect <= 1'b0;
      m.m_write      <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_wr) begin
            state  <= WR_ISSUE;
            line_q <= req_line;
            lane_q <= req_lane;
            oor_q  <= req_oor;
            if (!req_oor) begin
              m.m_address    <= req_line;
              m.m_byteenable <= lane_be(s.s_byteenable, req_lane);
              m.m_writedata  <= {4{s.s_writedata}};
              m.m_chipselect <= 1'b1;
              m.m_write      <= 1'b1;
            end
          end else if (accept_rd) begin
            line_q <= req_line;
            lane_q <= req_lane;
            oor_q  <= req_oor;
            if (req_oor || buf_hit) begin
              state <= RD_RESP;
            end else begin
              state          <= RD_ISSUE;
              m.m_address    <= req_line;
              m.m_byteenable <= '1;
              m.m_chipselect <= 1'b1;
            end
          end
        end
        WR_ISSUE: state <= IDLE;
        RD_ISSUE: state <= RD_WAIT;
        RD_WAIT:  state <= RD_RESP;
        RD_RESP:  state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_dmem_width_bridge.sv
// Directed self-checking bench for nios_dmem_width_bridge with a 1-cycle-latency RAM model.
module tb_nios_dmem_width_bridge;

  logic clk;
  logic reset_n;
  logic ram_init;
  int   checks;
  int   failures;

  nios_dmem_width_bridge_if #(.LINE_AW(15)) cpu ();
  nios_dmem_ram_if          #(.LINE_AW(15)) ram ();

  nios_dmem_width_bridge #(
    .LINE_AW (15),
    .DEPTH   (25000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s       (cpu),
    .m       (ram)
  );

  always #5 clk = ~clk;

  // Small RAM model: 64 lines indexed by the low address bits, byte-enabled writes, 1-cycle read.
  logic [127:0] mem [64];
  logic [127:0] rdq;
  assign ram.m_readdata = rdq;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      rdq <= '0;
    end else if (ram.m_clken && ram.m_chipselect) begin
      if (ram.m_write) begin
        for (int b = 0; b < 16; b++)
          if (ram.m_byteenable[b]) mem[ram.m_address[5:0]][8*b +: 8] <= ram.m_writedata[8*b +: 8];
      end else begin
        rdq <= mem[ram.m_address[5:0]];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [18:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    cpu.s_read       = rd;
    cpu.s_write      = wr;
    cpu.s_address    = a;
    cpu.s_byteenable = be;
    cpu.s_writedata  = d;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    reset_n  = 1'b0;
    ram_init = 1'b1;
    drive(0, 0, '0, '0, '0);
    step();
    step();
    chk("rst_clken",    ram.m_clken, 1);
    chk("rst_cs",       ram.m_chipselect, 0);
    chk("rst_mwrite",   ram.m_write, 0);
    chk("rst_maddr",    ram.m_address, 0);
    chk("rst_mbe",      ram.m_byteenable, 0);
    chk("rst_mwd",      ram.m_writedata, 0);
    chk("rst_rdata",    cpu.s_readdata, 0);
    chk("rst_rdv",      cpu.s_readdatavalid, 0);
    chk("rst_wait",     cpu.s_waitrequest, 0);
    ram_init = 1'b0;
    reset_n  = 1'b1;
    step();

    // write 0xDEADBEEF to line 2 lane 1
    drive(0, 1, 19'h00024, 4'hF, 32'hDEADBEEF);
    chk("wr1_wait_idle", cpu.s_waitrequest, 0);
    step();
    drive(0, 0, '0, '0, '0);
    chk("wr1_cs",    ram.m_chipselect, 1);
    chk("wr1_mwr",   ram.m_write, 1);
    chk("wr1_addr",  ram.m_address, 2);
    chk("wr1_be",    ram.m_byteenable, 16'h00F0);
    chk("wr1_wd",    ram.m_writedata[63:32], 32'hDEADBEEF);
    chk("wr1_wait",  cpu.s_waitrequest, 1);
    step();
    chk("wr1_idle_wait", cpu.s_waitrequest, 0);
    chk("wr1_idle_cs",   ram.m_chipselect, 0);

    // write 0x12345678 to line 2 lane 2 (buffer still invalid)
    drive(0, 1, 19'h00028, 4'hF, 32'h12345678);
    step();
    drive(0, 0, '0, '0, '0);
    chk("wr2_be", ram.m_byteenable, 16'h0F00);
    step();

    // cold read of 0x24: miss, latency 3
    drive(1, 0, 19'h00024, '0, '0);
    step();
    drive(0, 0, '0, '0, '0);
    chk("miss_cs",   ram.m_chipselect, 1);
    chk("miss_mwr",  ram.m_write, 0);
    chk("miss_be",   ram.m_byteenable, 16'hFFFF);
    chk("miss_addr", ram.m_address, 2);
    chk("miss_wait1", cpu.s_waitrequest, 1);
    chk("miss_rdv1", cpu.s_readdatavalid, 0);
    step();
    chk("miss_rdv2",  cpu.s_readdatavalid, 0);
    chk("miss_wait2", cpu.s_waitrequest, 1);
    chk("miss_cs2",   ram.m_chipselect, 0);
    step();
    chk("miss_rdv3",  cpu.s_readdatavalid, 1);
    chk("miss_data",  cpu.s_readdata, 32'hDEADBEEF);
    chk("miss_wait3", cpu.s_waitrequest, 1);
    step();
    chk("miss_rdv4",  cpu.s_readdatavalid, 0);
    chk("miss_wait4", cpu.s_waitrequest, 0);

    // read 0x28: hit, latency 1, no RAM access
    drive(1, 0, 19'h00028, '0, '0);
    step();
    drive(0, 0, '0, '0, '0);
    chk("hit_rdv",  cpu.s_readdatavalid, 1);
    chk("hit_data", cpu.s_readdata, 32'h12345678);
    chk("hit_cs",   ram.m_chipselect, 0);
    step();
    chk("hit_wait_after", cpu.s_waitrequest, 0);
    chk("hit_rdv_after",  cpu.s_readdatavalid, 0);

    // partial write into the buffered line, then hit read of merged word
    drive(0, 1, 19'h00028, 4'h3, 32'h0000AAAA);
    step();
    drive(0, 0, '0, '0, '0);
    chk("mrg_be", ram.m_byteenable, 16'h0300);
    chk("mrg_wd", ram.m_writedata, {4{32'h0000AAAA}});
    step();
    drive(1, 0, 19'h00028, '0, '0);
    step();
    drive(0, 0, '0, '0, '0);
    chk("mrg_rdv",  cpu.s_readdatavalid, 1);
    chk("mrg_data", cpu.s_readdata, 32'h1234AAAA);
    chk("mrg_cs",   ram.m_chipselect, 0);
    step();

    // out-of-range read at line 25000
    drive(1, 0, 19'h61A80, '0, '0);
    step();
    drive(0, 0, '0, '0, '0);
    chk("oor_rd_rdv",  cpu.s_readdatavalid, 1);
    chk("oor_rd_data", cpu.s_readdata, 0);
    chk("oor_rd_cs",   ram.m_chipselect, 0);
    step();

    // out-of-range write at line 25000
    drive(0, 1, 19'h61A80, 4'hF, 32'hFFFFFFFF);
    step();
    drive(0, 0, '0, '0, '0);
    chk("oor_wr_cs",   ram.m_chipselect, 0);
    chk("oor_wr_mwr",  ram.m_write, 0);
    chk("oor_wr_wait", cpu.s_waitrequest, 1);
    step();
    chk("oor_wr_idle", cpu.s_waitrequest, 0);

    // buffer must still hold line 2
    drive(1, 0, 19'h00024, '0, '0);
    step();
    drive(0, 0, '0, '0, '0);
    chk("keep_rdv",  cpu.s_readdatavalid, 1);
    chk("keep_data", cpu.s_readdata, 32'hDEADBEEF);
    chk("keep_cs",   ram.m_chipselect, 0);
    step();

    // read and write together: protocol violation, only the write happens
    $display("note: driving s_read and s_write together (protocol violation), expecting write only");
    drive(1, 1, 19'h00034, 4'hF, 32'hCAFEF00D);
    step();
    drive(0, 0, '0, '0, '0);
    chk("rw_cs",   ram.m_chipselect, 1);
    chk("rw_mwr",  ram.m_write, 1);
    chk("rw_addr", ram.m_address, 3);
    chk("rw_rdv1", cpu.s_readdatavalid, 0);
    step();
    chk("rw_rdv2", cpu.s_readdatavalid, 0);
    chk("rw_wait", cpu.s_waitrequest, 0);
    step();
    chk("rw_rdv3", cpu.s_readdatavalid, 0);

    // read back line 3 lane 1 through a miss
    drive(1, 0, 19'h00034, '0, '0);
    step();
    drive(0, 0, '0, '0, '0);
    chk("rb_cs", ram.m_chipselect, 1);
    step();
    step();
    chk("rb_rdv",  cpu.s_readdatavalid, 1);
    chk("rb_data", cpu.s_readdata, 32'hCAFEF00D);
    step();

    // last in-range line 24999 goes to RAM
    drive(1, 0, 19'h61A70, '0, '0);
    step();
    drive(0, 0, '0, '0, '0);
    chk("edge_cs",   ram.m_chipselect, 1);
    chk("edge_addr", ram.m_address, 24999);
    step();
    step();
    chk("edge_rdv",  cpu.s_readdatavalid, 1);
    chk("edge_data", cpu.s_readdata, 0);
    step();

    // reset asserted during RD_WAIT aborts the read
    drive(1, 0, 19'h00050, '0, '0);
    step();
    drive(0, 0, '0, '0, '0);
    step();
    chk("abort_wait_rdwait", cpu.s_waitrequest, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_wait_rst", cpu.s_waitrequest, 0);
    chk("abort_rdv_rst",  cpu.s_readdatavalid, 0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_rdv", cpu.s_readdatavalid, 0);
    end

    // buffer invalidated by reset: line 3 read misses again
    drive(1, 0, 19'h00034, '0, '0);
    step();
    drive(0, 0, '0, '0, '0);
    chk("postrst_cs", ram.m_chipselect, 1);
    step();
    step();
    chk("postrst_rdv",  cpu.s_readdatavalid, 1);
    chk("postrst_data", cpu.s_readdata, 32'hCAFEF00D);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nios_dmem_width_bridge.md
Name: nios_dmem_width_bridge

Overview:
- Avalon-MM bridge between the Nios II 32-bit data master and the 128-bit single-port on-chip RAM (15-bit line address, 16 byte-enables, 25000 lines).
- Sits directly upstream of the RAM and drives its s1 port.
- Converts 32-bit word accesses into 128-bit lane accesses.
- Holds a one-line read buffer so that sequential word reads within a line are served without a RAM access.
- Handles the RAM's fixed 1-cycle read latency.

Parameters:
- LINE_AW, 15, RAM line address width.
- DEPTH, 25000, number of valid 128-bit lines; line indices >= DEPTH are out of range.
- LANES, 4, 32-bit lanes per line (fixed; lane index is 2 bits).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- s_address  in  LINE_AW+4  byte address; [LINE_AW+3:4] = line, [3:2] = lane, [1:0] ignored.
- s_read  in  1  read request.
- s_write  in  1  write request.
- s_byteenable  in  4  byte enables for the 32-bit word.
- s_writedata  in  32  write data.
- s_waitrequest  out  1  high = request not accepted this cycle.
- s_readdata  out  32  read data.
- s_readdatavalid  out  1  one-cycle read response strobe.
- m_address  out  LINE_AW  RAM line address.
- m_byteenable  out  16  RAM byte enables.
- m_chipselect  out  1  RAM select.
- m_write  out  1  RAM write.
- m_writedata  out  128  RAM write data.
- m_clken  out  1  RAM clock enable; tied to 1.
- m_readdata  in  128  RAM read data, valid the cycle after the address cycle.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; line buffer invalid.
  - All m_* outputs 0 except m_clken = 1.
  - s_readdata = 0, s_readdatavalid = 0, s_waitrequest = 0.
- Reset mid-transaction aborts the transaction; no response is produced.
- States: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_RESP.
  - s_waitrequest = (state != IDLE), combinational.
  - A request is accepted only in IDLE.
- Simultaneous s_read and s_write: write wins; the read is dropped. The bench flags this as a protocol violation.
- Write, accepted in IDLE at cycle N:
  - Register line and lane.
  - m_writedata = s_writedata replicated in all 4 lanes.
  - m_byteenable = s_byteenable << (4*lane); other bits 0.
  - N+1, WR_ISSUE: m_chipselect = m_write = 1; then return to IDLE.
  - If the line buffer holds the same line, merge the enabled bytes into it at N+1, keeping it coherent.
- Read hit (buffer valid, tag == line), accepted at N:
  - N+1, RD_RESP: s_readdatavalid = 1, s_readdata = buffer lane.
  - No RAM access. Latency 1.
- Read miss, accepted at N:
  - N+1, RD_ISSUE: m_chipselect = 1, m_write = 0, m_byteenable = all ones.
  - N+2, RD_WAIT: capture m_readdata into the buffer; set tag and valid.
  - N+3, RD_RESP: readdatavalid with the selected lane. Latency 3.
- Out-of-range line (>= DEPTH):
  - Write: dropped; no RAM cycle; state returns to IDLE via WR_ISSUE with m_chipselect = 0.
  - Read: goes to RD_RESP at N+1 with s_readdata = 0; buffer unchanged.
- m_* outputs are registered. m_chipselect and m_write are high only in the issue cycles; m_address and m_byteenable hold their last value otherwise.
- Exactly one s_readdatavalid per accepted read; at most one outstanding read.

Decomposition:
- Shared package nios_dmem_pkg: state enum; LANES; lane/line field slice constants; function lane_be(be4, lane) returning 16 bits; function lane_sel(line128, lane) returning 32 bits.
- One sub-module is natural: nios_dmem_line_buf, holding the 128-bit data, tag and valid, with byte-merge write and lane read mux.
- The FSM stays in the top module.

Test Plan:
- Reset then idle: outputs at reset values, m_clken = 1, s_waitrequest = 0; assert reset_n low mid-RD_WAIT -> no readdatavalid after release.
- Write 0xDEADBEEF, be = 0xF, to byte address 0x00024 (line 2, lane 1) -> one cycle later m_address = 2, m_byteenable = 0x00F0, m_write = 1, writedata lane 1 = 0xDEADBEEF.
- Read 0x00024 cold -> RAM read of line 2; readdatavalid 3 cycles after accept with 0xDEADBEEF. Then read 0x00028 -> hit, 1-cycle latency, no m_chipselect.
- Line buffered, then write be = 0x3, data 0x0000AAAA to 0x00028, then read 0x00028 -> hit returns the merged word (low 16 bits 0xAAAA, upper bytes as before).
- Out-of-range: read at line 25000 (byte address 25000*16) -> readdatavalid 1 cycle later with 0, no RAM cycle; write at the same address -> no m_chipselect.
- Back-to-back reads: s_waitrequest high exactly during non-IDLE cycles; s_read and s_write asserted together -> only the write is performed.
